// File: rtl/id_buf_decoder.sv
// RV32I/RV64I (+M) decode stage: combinational decode of the incoming
// instruction feeding a small in-order FIFO of decoded bundles for EX.
module id_buf_decoder #(
   parameter int XLEN     = 32,
   parameter bit M_EXT_EN = 1'b1,
   parameter int DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            inst_valid_i,
   output logic            inst_ready_o,
   input  logic [31:0]     inst_data_i,
   input  logic [XLEN-1:0] inst_addr_i,
   output logic            dec_valid_o,
   input  logic            dec_ready_i,
   output logic [XLEN-1:0] dec_inst_addr_o,
   output logic [6:0]      opcode_o,
   output logic [4:0]      rd_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [2:0]      funct3_o,
   output logic [6:0]      funct7_o,
   output logic [5:0]      shamt_o,
   output logic [XLEN-1:0] imm_o,
   output logic            rd_we_o,
   output logic            rs1_used_o,
   output logic            rs2_used_o,
   output logic            illegal_o,
   output logic [15:0]     illegal_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [5:0]      shamt;
      logic [XLEN-1:0] imm;
      logic            rd_we;
      logic            rs1_used;
      logic            rs2_used;
      logic            illegal;
   } bundle_t;

   bundle_t          dec_d;
   bundle_t          head;
   bundle_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [15:0]      ill_cnt_q, ill_cnt_d;
   logic [31:0]      imm32;
   logic [6:0]       shift_hi;
   logic [6:0]       sra_hi;
   logic [2:0]       f3;
   logic             illegal;
   logic             push, pop;

   assign f3 = inst_data_i[14:12];
   // Bits above shamt on shift-immediates; on RV64 bit 25 belongs to shamt.
   assign shift_hi = (XLEN == 64) ? {1'b0, inst_data_i[31:26]} : inst_data_i[31:25];
   assign sra_hi   = (XLEN == 64) ? 7'b0010000 : 7'b0100000;

   // Full combinational decode of the offered instruction.
   always_comb begin
      dec_d          = '0;
      imm32          = '0;
      illegal        = 1'b0;
      dec_d.addr     = inst_addr_i;
      dec_d.opcode   = inst_data_i[6:0];
      dec_d.rd       = inst_data_i[11:7];
      dec_d.rs1      = inst_data_i[19:15];
      dec_d.rs2      = inst_data_i[24:20];
      dec_d.funct3   = f3;
      dec_d.rs1_used = 1'b1;
      case (inst_data_i[6:0])
         OPC_LUI, OPC_AUIPC: begin
            imm32          = {inst_data_i[31:12], 12'b0};
            dec_d.funct3   = 3'b000;
            dec_d.rs1_used = 1'b0;
         end
         OPC_JAL: begin
            imm32          = {{12{inst_data_i[31]}}, inst_data_i[19:12], inst_data_i[20],
                              inst_data_i[30:21], 1'b0};
            dec_d.funct3   = 3'b000;
            dec_d.rs1_used = 1'b0;
         end
         OPC_JALR: begin
            imm32   = {{20{inst_data_i[31]}}, inst_data_i[31:20]};
            illegal = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            imm32          = {{20{inst_data_i[31]}}, inst_data_i[7], inst_data_i[30:25],
                              inst_data_i[11:8], 1'b0};
            dec_d.rs2_used = 1'b1;
            illegal        = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            imm32   = {{20{inst_data_i[31]}}, inst_data_i[31:20]};
            illegal = (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
         end
         OPC_STORE: begin
            imm32          = {{20{inst_data_i[31]}}, inst_data_i[31:25], inst_data_i[11:7]};
            dec_d.rs2_used = 1'b1;
            illegal        = f3[2] || ((XLEN == 32) && (f3 == 3'b011));
         end
         OPC_OPIMM: begin
            imm32 = {{20{inst_data_i[31]}}, inst_data_i[31:20]};
            if (f3 == 3'b001 || f3 == 3'b101) begin
               dec_d.shamt = (XLEN == 64) ? inst_data_i[25:20] : {1'b0, inst_data_i[24:20]};
               if (f3 == 3'b001) illegal = (shift_hi != 7'd0);
               else              illegal = (shift_hi != 7'd0) && (shift_hi != sra_hi);
            end
         end
         OPC_OP: begin
            dec_d.funct7   = inst_data_i[31:25];
            dec_d.rs2_used = 1'b1;
            case (inst_data_i[31:25])
               7'b0000000: illegal = 1'b0;
               7'b0100000: illegal = !((f3 == 3'b000) || (f3 == 3'b101));
               7'b0000001: illegal = !M_EXT_EN;
               default:    illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
      if (inst_data_i[1:0] != 2'b11) illegal = 1'b1;
      dec_d.imm     = XLEN'($signed(imm32));
      dec_d.illegal = illegal;
      dec_d.rd_we   = !((inst_data_i[6:0] == OPC_STORE) || (inst_data_i[6:0] == OPC_BRANCH) || illegal);
   end

   assign inst_ready_o = (count_q != CNT_W'(DEPTH));
   assign dec_valid_o  = (count_q != '0);
   assign push         = inst_valid_i && inst_ready_o && !flush_i;
   assign pop          = dec_valid_o && dec_ready_i && !flush_i;

   // Pointer, occupancy and illegal-counter next state; flush wins over push/pop.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ill_cnt_d = ill_cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (push && dec_d.illegal && (ill_cnt_q != 16'hFFFF)) ill_cnt_d = ill_cnt_q + 16'd1;
      end
   end

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ill_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ill_cnt_q <= ill_cnt_d;
      end
   end

   // Bundle storage; contents only matter while counted, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= dec_d;
   end

   // Head bundle, forced to zero when empty so a reset never shows stale data.
   always_comb begin
      head = '0;
      if (dec_valid_o) head = mem_q[rd_ptr_q];
   end

   assign dec_inst_addr_o = head.addr;
   assign opcode_o        = head.opcode;
   assign rd_o            = head.rd;
   assign rs1_o           = head.rs1;
   assign rs2_o           = head.rs2;
   assign funct3_o        = head.funct3;
   assign funct7_o        = head.funct7;
   assign shamt_o         = head.shamt;
   assign imm_o           = head.imm;
   assign rd_we_o         = head.rd_we;
   assign rs1_used_o      = head.rs1_used;
   assign rs2_used_o      = head.rs2_used;
   assign illegal_o       = head.illegal;
   assign illegal_cnt_o   = ill_cnt_q;

endmodule

// File: tb/tb_id_buf_decoder.sv
// Bench for id_buf_decoder: two instances (M extension on / off) share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_id_buf_decoder;
   localparam int DEPTH = 2;

   localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
   localparam logic [6:0] BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23;
   localparam logic [6:0] OPIMM = 7'h13, OP = 7'h33;

   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, inst_valid = 1'b0, dec_ready = 1'b0;
   logic [31:0] inst_data = '0, inst_addr = '0;

   logic d1_iready, d1_dvalid, d1_we, d1_u1, d1_u2, d1_ill;
   logic [31:0] d1_addr, d1_imm;
   logic [6:0] d1_opc, d1_f7;
   logic [4:0] d1_rd, d1_rs1, d1_rs2;
   logic [2:0] d1_f3;
   logic [5:0] d1_sh;
   logic [15:0] d1_cnt;

   logic d0_iready, d0_dvalid, d0_we, d0_u1, d0_u2, d0_ill;
   logic [31:0] d0_addr, d0_imm;
   logic [6:0] d0_opc, d0_f7;
   logic [4:0] d0_rd, d0_rs1, d0_rs2;
   logic [2:0] d0_f3;
   logic [5:0] d0_sh;
   logic [15:0] d0_cnt;

   always #5 clk = ~clk;

   id_buf_decoder #(.XLEN(32), .M_EXT_EN(1'b1), .DEPTH(DEPTH)) dut_m1 (
      .clk(clk), .rst(rst), .flush_i(flush), .inst_valid_i(inst_valid),
      .inst_ready_o(d1_iready), .inst_data_i(inst_data), .inst_addr_i(inst_addr),
      .dec_valid_o(d1_dvalid), .dec_ready_i(dec_ready), .dec_inst_addr_o(d1_addr),
      .opcode_o(d1_opc), .rd_o(d1_rd), .rs1_o(d1_rs1), .rs2_o(d1_rs2),
      .funct3_o(d1_f3), .funct7_o(d1_f7), .shamt_o(d1_sh), .imm_o(d1_imm),
      .rd_we_o(d1_we), .rs1_used_o(d1_u1), .rs2_used_o(d1_u2),
      .illegal_o(d1_ill), .illegal_cnt_o(d1_cnt));

   id_buf_decoder #(.XLEN(32), .M_EXT_EN(1'b0), .DEPTH(DEPTH)) dut_m0 (
      .clk(clk), .rst(rst), .flush_i(flush), .inst_valid_i(inst_valid),
      .inst_ready_o(d0_iready), .inst_data_i(inst_data), .inst_addr_i(inst_addr),
      .dec_valid_o(d0_dvalid), .dec_ready_i(dec_ready), .dec_inst_addr_o(d0_addr),
      .opcode_o(d0_opc), .rd_o(d0_rd), .rs1_o(d0_rs1), .rs2_o(d0_rs2),
      .funct3_o(d0_f3), .funct7_o(d0_f7), .shamt_o(d0_sh), .imm_o(d0_imm),
      .rd_we_o(d0_we), .rs1_used_o(d0_u1), .rs2_used_o(d0_u2),
      .illegal_o(d0_ill), .illegal_cnt_o(d0_cnt));

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [5:0]  shamt;
      logic [31:0] imm;
      logic        rd_we, rs1_used, rs2_used, illegal;
   } exp_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
   } ent_t;

   ent_t        q[$];
   logic [15:0] cnt0 = '0, cnt1 = '0;
   int          total = 0, bad = 0;

   task automatic finish_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
         if (bad >= 200) finish_run();
      end
   endtask

   // Reference decode, written straight from the ISA field rules.
   function automatic exp_t model_dec(input logic [31:0] w, input bit m_en);
      exp_t e;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] hi;
      logic signed [31:0] sw;
      logic [31:0] s20, s19, s11;
      bit ok;
      op = w[6:0]; f3 = w[14:12]; hi = w[31:25]; sw = w;
      s20 = sw >>> 20; s19 = sw >>> 19; s11 = sw >>> 11;
      e = '0;
      e.opcode = op; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
      e.f3 = (op == LUI || op == AUIPC || op == JAL) ? 3'd0 : f3;
      e.f7 = (op == OP) ? hi : 7'd0;
      e.shamt = (op == OPIMM && f3[1:0] == 2'b01) ? {1'b0, w[24:20]} : 6'd0;
      case (op)
         LOAD, OPIMM, JALR: e.imm = s20;
         STORE:      e.imm = (s20 & ~32'h1F) | 32'(w[11:7]);
         BRANCH:     e.imm = (s19 & 32'hFFFFF000) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
         JAL:        e.imm = (s11 & 32'hFFF00000) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
         LUI, AUIPC: e.imm = w & 32'hFFFFF000;
         default:    e.imm = 32'd0;
      endcase
      case (op)
         LUI, AUIPC, JAL: ok = 1'b1;
         JALR:   ok = (f3 == 3'd0);
         BRANCH: ok = !(f3 == 3'd2 || f3 == 3'd3);
         LOAD:   ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
         STORE:  ok = (f3 <= 3'd2);
         OPIMM: begin
            if (f3 == 3'd1)      ok = (hi == 7'h00);
            else if (f3 == 3'd5) ok = (hi == 7'h00 || hi == 7'h20);
            else                 ok = 1'b1;
         end
         OP:      ok = (hi == 7'h00) || (hi == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (hi == 7'h01 && m_en);
         default: ok = 1'b0;
      endcase
      e.illegal  = !ok;
      e.rs1_used = !(op == LUI || op == AUIPC || op == JAL);
      e.rs2_used = (op == OP || op == STORE || op == BRANCH);
      e.rd_we    = ok && !(op == STORE || op == BRANCH);
      return e;
   endfunction

   // FIFO model: plain queue of raw instructions, updated on each clock edge.
   always @(posedge clk or posedge rst) begin
      bit acc, pp;
      exp_t e1, e0;
      if (rst) begin
         q.delete();
         cnt0 = '0;
         cnt1 = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         acc = inst_valid && (q.size() != DEPTH);
         pp  = (q.size() != 0) && dec_ready;
         if (pp) void'(q.pop_front());
         if (acc) begin
            q.push_back({inst_data, inst_addr});
            e1 = model_dec(inst_data, 1'b1);
            e0 = model_dec(inst_data, 1'b0);
            if (e1.illegal && cnt1 != 16'hFFFF) cnt1 = cnt1 + 16'd1;
            if (e0.illegal && cnt0 != 16'hFFFF) cnt0 = cnt0 + 16'd1;
         end
      end
   end

   task automatic cmp_dut(input string t, input bit m_en, input logic iready, input logic dvalid,
                          input logic [31:0] addr, input logic [6:0] opc, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [5:0] sh, input logic [31:0] imm,
                          input logic we, input logic u1, input logic u2, input logic ill,
                          input logic [15:0] cnt);
      exp_t e;
      logic [31:0] ea;
      e = '0; ea = '0;
      if (q.size() != 0) begin
         e  = model_dec(q[0].inst, m_en);
         ea = q[0].addr;
      end
      chk({t, ".inst_ready"}, iready, q.size() != DEPTH);
      chk({t, ".dec_valid"}, dvalid, q.size() != 0);
      chk({t, ".addr"}, addr, ea);
      chk({t, ".opcode"}, opc, e.opcode);
      chk({t, ".rd"}, rd, e.rd);
      chk({t, ".rs1"}, rs1, e.rs1);
      chk({t, ".rs2"}, rs2, e.rs2);
      chk({t, ".funct3"}, f3, e.f3);
      chk({t, ".funct7"}, f7, e.f7);
      chk({t, ".shamt"}, sh, e.shamt);
      chk({t, ".imm"}, imm, e.imm);
      chk({t, ".rd_we"}, we, e.rd_we);
      chk({t, ".rs1_used"}, u1, e.rs1_used);
      chk({t, ".rs2_used"}, u2, e.rs2_used);
      chk({t, ".illegal"}, ill, e.illegal);
      chk({t, ".illegal_cnt"}, cnt, m_en ? cnt1 : cnt0);
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      cmp_dut("m1", 1'b1, d1_iready, d1_dvalid, d1_addr, d1_opc, d1_rd, d1_rs1, d1_rs2, d1_f3,
              d1_f7, d1_sh, d1_imm, d1_we, d1_u1, d1_u2, d1_ill, d1_cnt);
      cmp_dut("m0", 1'b0, d0_iready, d0_dvalid, d0_addr, d0_opc, d0_rd, d0_rs1, d0_rs2, d0_f3,
              d0_f7, d0_sh, d0_imm, d0_we, d0_u1, d0_u2, d0_ill, d0_cnt);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [31:0] pc = 32'h1000;

   task automatic send1(input logic [31:0] w);
      inst_valid = 1'b1;
      inst_data  = w;
      inst_addr  = pc;
      pc         = pc + 32'd4;
      tick();
      inst_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0] ops [9];
      int k;
      ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
      w = $urandom;
      k = $urandom_range(0, 10);
      if (k < 9) w[6:0] = ops[k];
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         2: w[31:25] = 7'h01;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      tick();
      tick();
      rst = 1'b0;
      dec_ready = 1'b1;

      send1(32'hFFF00093);
      chk("addi.valid", d1_dvalid, 1);
      chk("addi.rd", d1_rd, 1);
      chk("addi.rs1", d1_rs1, 0);
      chk("addi.imm", d1_imm, 32'hFFFFFFFF);
      chk("addi.rd_we", d1_we, 1);
      chk("addi.rs2_used", d1_u2, 0);
      chk("addi.illegal", d1_ill, 0);
      tick();
      send1(32'hFE20AE23);
      chk("sw.imm", d1_imm, 32'hFFFFFFFC);
      chk("sw.rs1", d1_rs1, 1);
      chk("sw.rs2", d1_rs2, 2);
      chk("sw.rd_we", d1_we, 0);
      chk("sw.rs2_used", d1_u2, 1);
      tick();
      send1(32'hFE000EE3);
      chk("beq.imm", d1_imm, 32'hFFFFFFFC);
      chk("beq.funct3", d1_f3, 0);
      chk("beq.rd_we", d1_we, 0);
      tick();
      send1(32'h123452B7);
      chk("lui.imm", d1_imm, 32'h12345000);
      chk("lui.rs1_used", d1_u1, 0);
      chk("lui.rd", d1_rd, 5);
      tick();
      chk("mul.cnt0_before", d0_cnt, 0);
      send1(32'h022081B3);
      chk("mul.m0.illegal", d0_ill, 1);
      chk("mul.m0.rd_we", d0_we, 0);
      chk("mul.m0.cnt", d0_cnt, 1);
      chk("mul.m1.illegal", d1_ill, 0);
      chk("mul.m1.funct7", d1_f7, 7'h01);
      chk("mul.m1.cnt", d1_cnt, 0);
      tick();

      // Back-pressure: offer DEPTH+2 instructions with EX stalled.
      dec_ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         inst_valid = 1'b1;
         inst_data  = 32'h00000013;
         inst_addr  = 32'h2000 + 32'(i * 4);
         tick();
      end
      inst_valid = 1'b0;
      chk("bp.full_ready", d1_iready, 0);
      chk("bp.head_addr", d1_addr, 32'h2000);
      dec_ready = 1'b1;
      tick();
      chk("bp.ready_back", d1_iready, 1);
      chk("bp.second_addr", d1_addr, 32'h2004);
      tick();
      chk("bp.drained", d1_dvalid, 0);

      // Flush with a full FIFO and an illegal instruction offered.
      dec_ready = 1'b0;
      send1(32'h00000013);
      send1(32'h00000013);
      chk("fl.full", d1_iready, 0);
      flush = 1'b1; inst_valid = 1'b1; inst_data = 32'h0;
      tick();
      flush = 1'b0; inst_valid = 1'b0;
      chk("fl.valid", d1_dvalid, 0);
      chk("fl.ready", d1_iready, 1);
      chk("fl.cnt", d0_cnt, 1);
      // Flush with one entry: the offered illegal input must not be counted.
      send1(32'h00000013);
      flush = 1'b1; inst_valid = 1'b1; inst_data = 32'h0;
      tick();
      flush = 1'b0; inst_valid = 1'b0;
      chk("fl1.valid", d0_dvalid, 0);
      chk("fl1.cnt", d0_cnt, 1);

      // Asynchronous reset mid-stream.
      send1(32'hFFF00093);
      rst = 1'b1;
      #1;
      chk("rst.valid", d1_dvalid, 0);
      chk("rst.ready", d1_iready, 1);
      chk("rst.imm", d1_imm, 0);
      chk("rst.rd", d1_rd, 0);
      chk("rst.cnt", d0_cnt, 0);
      tick();
      rst = 1'b0;

      // Randomised traffic with occasional flushes and resets.
      for (int n = 0; n < 4000; n++) begin
         inst_valid = ($urandom_range(0, 9) < 7);
         dec_ready  = ($urandom_range(0, 9) < 6);
         flush      = ($urandom_range(0, 39) == 0);
         inst_data  = rand_inst();
         inst_addr  = $urandom & 32'hFFFFFFFC;
         if ($urandom_range(0, 499) == 0) rst = 1'b1;
         tick();
         rst = 1'b0;
      end
      flush = 1'b0;

      // Saturation of the illegal counter.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dec_ready  = 1'b1;
      inst_valid = 1'b1;
      inst_data  = 32'h0;
      for (int n = 0; n < 65534; n++) tick();
      chk("sat.below", d0_cnt, 16'hFFFE);
      for (int n = 0; n < 6; n++) tick();
      chk("sat.m0", d0_cnt, 16'hFFFF);
      chk("sat.m1", d1_cnt, 16'hFFFF);
      inst_valid = 1'b0;
      tick();
      tick();
      finish_run();
   end
endmodule

// File: doc/id_buf_decoder.md
Name: id_buf_decoder

Overview:
Parametrised, registered RV32I/RV64I (+ optional M) decode stage. It sits between IF and EX.
- Instructions enter through a valid/ready handshake, are fully decoded (sign-extended immediates, register-use flags, illegal detection) and are pushed into a DEPTH-entry FIFO.
- EX pops decoded bundles in order through a second valid/ready handshake.
- Supports flush and keeps a saturating count of illegal instructions.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sets imm/addr width and shamt rules.
- M_EXT_EN, 1, 1 = funct7 0000001 on OP opcode is legal (MUL/DIV family); 0 = illegal.
- DEPTH, 2, decoded-bundle FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all buffered entries and the current input.
- inst_valid_i  in  1  IF offers an instruction.
- inst_ready_o  out  1  stage can accept (FIFO not full).
- inst_data_i  in  32  raw instruction.
- inst_addr_i  in  XLEN  instruction PC.
- dec_valid_o  out  1  head bundle valid (FIFO not empty).
- dec_ready_i  in  1  EX consumes head bundle.
- dec_inst_addr_o  out  XLEN  PC of head bundle.
- opcode_o  out  7  inst[6:0].
- rd_o / rs1_o / rs2_o  out  5 each  register indices.
- funct3_o  out  3  inst[14:12], or 0 for LUI/AUIPC/JAL.
- funct7_o  out  7  inst[31:25] for OP, else 0.
- shamt_o  out  6  shift amount; bit 5 is always 0 when XLEN=32.
- imm_o  out  XLEN  sign-extended immediate.
- rd_we_o / rs1_used_o / rs2_used_o  out  1 each  register write / read flags.
- illegal_o  out  1  head bundle is an illegal instruction.
- illegal_cnt_o  out  16  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers, count and illegal_cnt are cleared.
  - All outputs read 0, except inst_ready_o, which is 1 once count = 0.
- Accept: inst_valid_i & inst_ready_o & !flush_i. The combinational decode of inst_data_i is written to the tail entry.
- Pop: dec_valid_o & dec_ready_i & !flush_i. The head pointer advances.
- Ready/valid derivation:
  - inst_ready_o = (count != DEPTH); it depends only on registered count, with no combinational path from dec_ready_i.
  - dec_valid_o = (count != 0).
  - Bundle outputs are driven from the head entry; they are 0 when the FIFO is empty.
- Latency: an accepted instruction appears on dec_valid_o the next cycle if the FIFO was empty.
- Throughput: 1 instruction/cycle when dec_ready_i is held high.
- Simultaneous push and pop: count is unchanged. Allowed at any non-full count; no push occurs when full.
- Pointers wrap modulo DEPTH.
- Flush has priority over push and pop: count = 0 next cycle, input is dropped, and illegal_cnt is not incremented for that input.
- Immediate formats, all sign-extended from inst[31] to XLEN:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH; bit 0 = 0.
  - U: LUI, AUIPC; low 12 bits = 0.
  - J: JAL; bit 0 = 0.
  - R-type: imm = 0.
- Shifts:
  - OP-IMM shift immediates: shamt = inst[25:20] (XLEN=64) or inst[24:20] (XLEN=32).
  - For other opcodes, shamt = 0.
- Register flags:
  - rd_we = 0 for STORE, BRANCH and illegal instructions; 1 otherwise.
  - rs1_used = 0 for LUI, AUIPC, JAL.
  - rs2_used = 1 only for OP, STORE, BRANCH.
- Illegal when any of:
  - inst[1:0] != 2'b11.
  - Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}.
  - JALR funct3 != 0.
  - BRANCH funct3 in {010, 011}.
  - LOAD funct3 = 111, or 011/110 when XLEN=32.
  - STORE funct3 >= 100, or 011 when XLEN=32.
  - SLLI with upper bits != 0.
  - SRLI/SRAI upper bits other than 0 or 0100000 (bit 25 counts as an upper bit when XLEN=32).
  - OP funct7 not in {0000000; 0100000 with funct3 000/101; 0000001 when M_EXT_EN=1}.
- For illegal instructions, the other fields are still decoded and presented.
- illegal_cnt increments on each accepted illegal instruction and saturates at 0xFFFF.
- Reset mid-operation: all state is cleared immediately. Entries in flight are lost, with no partial bundle on the outputs.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), dec_ready_i=1 -> next cycle dec_valid_o=1, rd=1, rs1=0, imm=0xFFFFFFFF, rd_we=1, rs2_used=0, illegal=0.
- sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, rs1=1, rs2=2, rd_we=0, rs2_used=1.
- beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, funct3=0, rd_we=0. lui x5,0x12345 (0x123452B7) -> imm=0x12345000, rs1_used=0.
- M_EXT_EN=0, mul x3,x1,x2 (0x022081B3) -> illegal=1, rd_we=0, illegal_cnt 0->1. Same input with M_EXT_EN=1 -> illegal=0, funct7=0x01.
- dec_ready_i=0, stream DEPTH+2 instructions -> inst_ready_o=0 after DEPTH accepts. Then dec_ready_i=1 -> bundles pop in PC order, 1/cycle, and inst_ready_o returns the cycle after the first pop.
- FIFO holding 2 entries, flush_i=1 with inst_valid_i=1 -> next cycle dec_valid_o=0, inst_ready_o=1, illegal_cnt unchanged. rst pulse mid-stream -> all outputs 0 asynchronously.
